// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and FSM state type for the sequential multiplier
package mult_pkg;
    localparam int LARGURA = 32;
    localparam int N_ITER  = LARGURA;
    localparam int CNT_W   = $clog2(N_ITER + 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        NEGA   = 2'd2,
        FIM    = 2'd3
    } estado_t;
endpackage

// File: rtl/somador_32bits.sv
// rtl/somador_32bits.sv - 32-bit ripple-carry adder
module somador_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c0,
    output logic [31:0] s,
    output logic        c32
);
    logic carry;

    // Carry rippled through a loop variable keeps the chain inside one process.
    always_comb begin
        carry = c0;
        s     = '0;
        for (int i = 0; i < 32; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c32 = carry;
    end
endmodule

// File: rtl/multiplicador_seq.sv
// rtl/multiplicador_seq.sv - shift-and-add 32x32->64 multiplier; optional MULT_SINAL_EN adds signed mode
module multiplicador_seq #(
    parameter int LARGURA = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inicio,
    input  logic [LARGURA-1:0]     a,
    input  logic [LARGURA-1:0]     b,
`ifdef MULT_SINAL_EN
    input  logic                   com_sinal,
`endif
    output logic                   ocupado,
    output logic                   pronto,
    output logic [2*LARGURA-1:0]   produto
);
    import mult_pkg::*;

    estado_t                estado_q, estado_d;
    logic [LARGURA-1:0]     m_q, m_d;
    logic [2*LARGURA-1:0]   p_q, p_d;
    logic [2*LARGURA-1:0]   produto_q, produto_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [LARGURA-1:0]     soma;
    logic                   carry;
    logic [LARGURA-1:0]     hi_sel;
    logic                   c_sel;
    logic [2*LARGURA-1:0]   p_shift;
    logic [LARGURA-1:0]     a_cap, b_cap;
    logic                   aceita, ultimo, vai_nega;

    somador_32bits u_somador (
        .a   (p_q[2*LARGURA-1:LARGURA]),
        .b   (m_q),
        .c0  (1'b0),
        .s   (soma),
        .c32 (carry)
    );

`ifdef MULT_SINAL_EN
    logic neg_q, neg_d, sinal_q, sinal_d;

    // Signed operands are reduced to magnitudes; -2^31 maps onto itself as unsigned 2^31.
    assign a_cap    = (com_sinal && a[LARGURA-1]) ? (~a + LARGURA'(1)) : a;
    assign b_cap    = (com_sinal && b[LARGURA-1]) ? (~b + LARGURA'(1)) : b;
    assign vai_nega = neg_q;
`else
    assign a_cap    = a;
    assign b_cap    = b;
    assign vai_nega = 1'b0;
`endif

    assign aceita  = inicio && ((estado_q == OCIOSO) || (estado_q == FIM));
    assign ultimo  = (cnt_q == CNT_W'(N_ITER - 1));
    assign hi_sel  = p_q[0] ? soma : p_q[2*LARGURA-1:LARGURA];
    assign c_sel   = p_q[0] & carry;
    // Carry-out becomes the new MSB as the 65-bit accumulator shifts right.
    assign p_shift = {c_sel, hi_sel, p_q[LARGURA-1:1]};

    always_comb begin
        estado_d  = estado_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        produto_d = produto_q;
`ifdef MULT_SINAL_EN
        neg_d     = neg_q;
        sinal_d   = sinal_q;
`endif
        case (estado_q)
            OCIOSO, FIM: begin
                estado_d = OCIOSO;
                if (aceita) begin
                    estado_d = CALC;
                    m_d      = a_cap;
                    p_d      = {{LARGURA{1'b0}}, b_cap};
                    cnt_d    = '0;
`ifdef MULT_SINAL_EN
                    neg_d    = com_sinal;
                    sinal_d  = com_sinal & (a[LARGURA-1] ^ b[LARGURA-1]);
`endif
                end
            end
            CALC: begin
                p_d   = p_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (ultimo) begin
                    if (vai_nega) begin
                        estado_d = NEGA;
                    end else begin
                        estado_d  = FIM;
                        produto_d = p_shift;
                    end
                end
            end
`ifdef MULT_SINAL_EN
            NEGA: begin
                if (sinal_q) begin
                    p_d = ~p_q + (2*LARGURA)'(1);
                end
                estado_d  = FIM;
                produto_d = p_d;
            end
`endif
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            m_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            produto_q <= '0;
`ifdef MULT_SINAL_EN
            neg_q     <= 1'b0;
            sinal_q   <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            produto_q <= produto_d;
`ifdef MULT_SINAL_EN
            neg_q     <= neg_d;
            sinal_q   <= sinal_d;
`endif
        end
    end

    assign ocupado = (estado_q == CALC) || (estado_q == NEGA);
    assign pronto  = (estado_q == FIM);
    assign produto = produto_q;
endmodule
